result_collector: RTL and testbench

//   Downstream stage of the operand feeder + bfm pair. Captures each bfm result res_o,

---
 rtl/result_collector.sv | 125 ++++++++++++
 tb/tb_result_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Result checker and FWFT result FIFO: realigns each res_i with the operand pair that
// produced it, counts mismatches, and drains results over a valid/ready stream with batch tlast.
module result_collector #(
    parameter int DATA_W     = 8,
    parameter int NUM        = 100,
    parameter int LAT        = 1,
    parameter int OP         = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              op_valid_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] res_i,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tlast_o,
    output logic              batch_done_o,
    output logic [15:0]       mismatch_cnt_o,
    output logic [15:0]       item_cnt_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [DATA_W-1:0] exp_now;
    logic              vld_pipe_reg [LAT];
    logic [DATA_W-1:0] exp_pipe_reg [LAT];

    logic [DATA_W:0]   mem_reg [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic [IW-1:0]     batch_idx_reg;
    logic [15:0]       item_cnt_reg, mismatch_cnt_reg;
    logic              overflow_reg, batch_done_reg;

    logic check, is_last, empty, full, push, pop;

    always_comb begin
        exp_now = a_i + b_i;
        case (OP)
            1:       exp_now = a_i - b_i;
            2:       exp_now = a_i ^ b_i;
            default: exp_now = a_i + b_i;
        endcase
    end

    // Stage i holds the operand pair sampled i+1 cycles ago; the last stage lines up with res_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < LAT; i++) begin
                vld_pipe_reg[i] <= 1'b0;
                exp_pipe_reg[i] <= '0;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                vld_pipe_reg[i] <= vld_pipe_reg[i-1];
                exp_pipe_reg[i] <= exp_pipe_reg[i-1];
            end
            vld_pipe_reg[0] <= op_valid_i;
            exp_pipe_reg[0] <= exp_now;
        end
    end

    assign check   = vld_pipe_reg[LAT-1];
    assign is_last = (batch_idx_reg == IW'(NUM - 1));

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = !empty && m_tready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = check && (!full || pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= {is_last, res_i};
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Counters and batch index advance on every check, even when the item is dropped.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            batch_idx_reg    <= '0;
            item_cnt_reg     <= '0;
            mismatch_cnt_reg <= '0;
            overflow_reg     <= 1'b0;
            batch_done_reg   <= 1'b0;
        end else begin
            batch_done_reg <= pop && m_tlast_o;
            if (check) begin
                item_cnt_reg  <= item_cnt_reg + 16'd1;
                batch_idx_reg <= is_last ? '0 : batch_idx_reg + 1'b1;
                if (res_i != exp_pipe_reg[LAT-1] && mismatch_cnt_reg != 16'hFFFF) begin
                    mismatch_cnt_reg <= mismatch_cnt_reg + 16'd1;
                end
                if (full && !pop) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    assign m_tvalid_o              = !empty;
    assign {m_tlast_o, m_tdata_o}  = mem_reg[rd_ptr_reg[AW-1:0]];
    assign batch_done_o            = batch_done_reg;
    assign mismatch_cnt_o          = mismatch_cnt_reg;
    assign item_cnt_o              = item_cnt_reg;
    assign overflow_o              = overflow_reg;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: bfm model with programmable corruption, scoreboard on the stream port.
module tb_result_collector;

    localparam int DW    = 8;
    localparam int NUM   = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          op_valid_i = 1'b0;
    logic [DW-1:0] a_i = '0, b_i = '0, res_i = '0;
    logic          m_tvalid_o, m_tready_i = 1'b0;
    logic [DW-1:0] m_tdata_o;
    logic          m_tlast_o, batch_done_o, overflow_o;
    logic [15:0]   mismatch_cnt_o, item_cnt_o;

    result_collector #(
        .DATA_W(DW), .NUM(NUM), .LAT(LAT), .OP(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .op_valid_i(op_valid_i),
        .a_i(a_i), .b_i(b_i), .res_i(res_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
        .m_tdata_o(m_tdata_o), .m_tlast_o(m_tlast_o),
        .batch_done_o(batch_done_o), .mismatch_cnt_o(mismatch_cnt_o),
        .item_cnt_o(item_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            bad;
        logic [DW-1:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_xfer = 0;
    int m_items = 0;
    int m_mis = 0;
    int m_idx = 0;
    bit done_pend = 0;
    logic [DW:0]   sb_q [$];
    logic [DW-1:0] hist_res [LAT];
    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One cycle of stimulus; called 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input bit bad, input logic [DW-1:0] exp, input bit rdy);
        logic [DW-1:0] sum;
        sum        = a + b;
        op_valid_i = v;
        a_i        = a;
        b_i        = b;
        m_tready_i = rdy;
        res_i      = hist_res[LAT-1];
        for (int i = LAT - 1; i > 0; i--) hist_res[i] = hist_res[i-1];
        hist_res[0] = bad ? 8'hAA : sum;
        if (v) begin
            sb_q.push_back({(m_idx == NUM - 1), exp});
            m_items++;
            if (bad) m_mis++;
            m_idx = (m_idx == NUM - 1) ? 0 : m_idx + 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, rdy);
    endtask

    task automatic item(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rdy);
        logic [DW-1:0] s;
        s = a + b;
        step(1'b1, a, b, 1'b0, s, rdy);
    endtask

    task automatic clear_model();
        sb_q.delete();
        for (int i = 0; i < LAT; i++) hist_res[i] = '0;
        m_items = 0;
        m_mis = 0;
        m_idx = 0;
        op_valid_i = 1'b0;
        m_tready_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    // Stream monitor: sampled on the falling edge, so a beat seen here transfers on the next rising edge.
    always @(negedge clk_i) begin
        logic [DW:0] e;
        if (reset_i) begin
            done_pend = 0;
        end else begin
            check("batch_done", int'(batch_done_o), int'(done_pend));
            if (batch_done_o) n_done++;
            done_pend = 0;
            if (m_tvalid_o && m_tready_i) begin
                n_xfer++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL beat: got unexpected %0h with empty scoreboard", {m_tlast_o, m_tdata_o});
                end else begin
                    e = sb_q.pop_front();
                    check("beat {last,data}", int'({m_tlast_o, m_tdata_o}), int'(e));
                    done_pend = e[DW];
                end
            end
        end
    end

    initial begin
        int d0, x0;
        vecs[0] = '{8'd3,   8'd4,   1'b0, 8'd7};
        vecs[1] = '{8'd255, 8'd1,   1'b0, 8'd0};
        vecs[2] = '{8'd10,  8'd20,  1'b0, 8'd30};
        vecs[3] = '{8'd5,   8'd6,   1'b0, 8'd11};
        vecs[4] = '{8'd9,   8'd9,   1'b1, 8'hAA};
        vecs[5] = '{8'd200, 8'd100, 1'b0, 8'd44};
        vecs[6] = '{8'd1,   8'd1,   1'b0, 8'd2};
        vecs[7] = '{8'd128, 8'd128, 1'b0, 8'd0};
        clear_model();

        // Reset state
        #2;
        check("rst tvalid", int'(m_tvalid_o), 0);
        check("rst tdata", int'(m_tdata_o), 0);
        check("rst tlast", int'(m_tlast_o), 0);
        check("rst item_cnt", int'(item_cnt_o), 0);
        check("rst mismatch", int'(mismatch_cnt_o), 0);
        check("rst overflow", int'(overflow_o), 0);
        do_reset();

        // Correct sums, then one corrupted result among five
        for (int i = 0; i < 3; i++) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].bad, vecs[i].exp, 1'b1);
        idle(LAT + 3, 1'b1);
        check("t1 item_cnt", int'(item_cnt_o), m_items);
        check("t1 mismatch", int'(mismatch_cnt_o), m_mis);
        for (int i = 3; i < 8; i++) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].bad, vecs[i].exp, 1'b1);
        idle(LAT + 3, 1'b1);
        check("t2 item_cnt", int'(item_cnt_o), 8);
        check("t2 mismatch", int'(mismatch_cnt_o), 1);

        // Two full batches back to back
        d0 = n_done;
        for (int i = 0; i < 8; i++) item(8'(i * 7), 8'(i + 40), 1'b1);
        idle(LAT + 4, 1'b1);
        check("t3 batch_done pulses", n_done - d0, 2);
        check("t3 overflow", int'(overflow_o), 0);
        check("t3 sb empty", sb_q.size(), 0);

        // Overflow: 17 items with the consumer stalled; the 17th is dropped
        for (int i = 0; i < 17; i++) item(8'(i * 13), 8'(i), 1'b0);
        idle(LAT + 2, 1'b0);
        void'(sb_q.pop_back());
        check("t4 overflow", int'(overflow_o), 1);
        check("t4 tvalid", int'(m_tvalid_o), 1);
        check("t4 item_cnt", int'(item_cnt_o), m_items);
        idle(24, 1'b1);
        check("t4 sb drained", sb_q.size(), 0);
        check("t4 tvalid empty", int'(m_tvalid_o), 0);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) item(8'(i + 100), 8'(i * 3), 1'b0);
        idle(LAT + 1, 1'b0);
        for (int i = 0; i < 8; i++) item(8'(i + 60), 8'(i * 5), (i >= LAT));
        idle(LAT, 1'b1);
        idle(2, 1'b0);
        check("t5 overflow", int'(overflow_o), 0);
        x0 = n_xfer;
        idle(22, 1'b1);
        check("t5 occupancy", n_xfer - x0, 16);
        check("t5 sb drained", sb_q.size(), 0);

        // Reset mid-stream with entries queued and items in flight
        for (int i = 0; i < 5; i++) item(8'(i + 1), 8'(i + 2), 1'b0);
        idle(LAT + 1, 1'b0);
        check("t6 pre tvalid", int'(m_tvalid_o), 1);
        for (int i = 0; i < 3; i++) item(8'(i + 9), 8'(i), 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check("t6 tvalid in reset", int'(m_tvalid_o), 0);
        check("t6 item_cnt in reset", int'(item_cnt_o), 0);
        check("t6 mismatch in reset", int'(mismatch_cnt_o), 0);
        check("t6 overflow in reset", int'(overflow_o), 0);
        clear_model();
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        idle(LAT + 6, 1'b1);
        check("t6 tvalid after", int'(m_tvalid_o), 0);
        check("t6 item_cnt after", int'(item_cnt_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
